uart_frame_tx: RTL
==================

Name: uart_frame_tx

Overview:
- Transmit side of the badge UART command protocol.
- Takes a command byte plus a 16-byte payload and builds the 18-byte frame {cmd, payload, cmd}, where the trailing cmd is the endchar.
- Serializes the frame as 8N1 on the interconnect TX line, so one badge can drive another badge's command decoder.
- Bit timing matches the existing uart_top baud generator: BR_LIMIT clocks per tick, SAMPLES ticks per bit.

Parameters:
- BR_LIMIT, 672, clocks per baud tick (103.34 MHz / 672 gives 16x 9600).
- BR_BITS, 10, width of the baud tick counter; must satisfy 2^BR_BITS > BR_LIMIT.
- SAMPLES, 16, baud ticks per serial bit.
- FRAME_BYTES, 18, bytes per frame; fixed at 18, other values unsupported.
- GAP_BITS, 1, extra idle bit-times inserted after each stop bit (only with UART_FRAME_TX_GAP_EN).

Ports:
- clk  in  1  system clock (OSCG internal oscillator domain)
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to send one frame; sampled on clk rising edge
- cmd  in  8  command byte; sent as byte 0 and byte 17
- payload  in  128  payload; payload[7:0] is byte 1, payload[127:120] is byte 16
- busy  out  1  high while a frame is in flight
- done  out  1  one-cycle pulse when the final stop bit completes
- byte_idx  out  5  index (0..17) of the byte currently on the line; 0 when idle
- tx  out  1  serial line; idles high

Behaviour:
- Reset (async): tx=1, busy=0, done=0, byte_idx=0, state=IDLE, all counters=0. Reset asserted mid-frame aborts immediately; tx returns high with no partial byte completion.
- Frame register: on acceptance, {cmd, payload, cmd} is latched into a 144-bit shift buffer. Later changes to cmd/payload have no effect on the frame in flight.
- Acceptance: start=1 is accepted in IDLE, or in the cycle done=1 (back-to-back). Otherwise start is ignored, with no queuing and no error.
- Latency: start accepted at edge N gives busy=1 and tx=0 (start bit) from edge N+1.
- Bit period: BR_LIMIT*SAMPLES clocks exactly. Tick counter is 0..BR_LIMIT-1; sample counter is 0..SAMPLES-1. Both counters reset at every bit boundary.
- FSM:
  - IDLE: tx=1. Goes to START on start.
  - START: tx=0 for one bit. Goes to DATA with bit count 0.
  - DATA: tx=current byte bit, LSB first. Advances after 8 bits to STOP.
  - STOP: tx=1 for one bit. If byte_idx<17, goes to GAP (if enabled) or START with byte_idx+1. If byte_idx=17, goes to IDLE.
  - GAP (feature only): tx=1 for GAP_BITS bit-times, then goes to START.
- Byte order: byte 0 (cmd) first, then payload bytes 1..16, then endchar byte 17 (= cmd).
- Completion: done=1 for exactly one cycle, on the edge after the last stop-bit clock. busy falls on that same edge unless start is accepted (then busy stays 1 and byte_idx resets to 0).
- Frame length without the feature: 180 bit-times = 180*BR_LIMIT*SAMPLES clocks from the first tx=0 to done.
- tx is registered (glitch-free) and drives interconnect[1] directly in MODE_UART.

Optional Feature:
- Macro UART_FRAME_TX_GAP_EN.
- Defined: the GAP state is compiled in. Each stop bit is followed by GAP_BITS idle bit-times, for a frame length of 18*(10+GAP_BITS)-GAP_BITS bit-times; no gap follows byte 17. This gives slow receivers margin and stays protocol-compatible.
- Undefined: no GAP state and no gap counter; bytes are sent back-to-back.

Test Plan:
All scenarios use BR_LIMIT=1, SAMPLES=4 (4 clocks/bit).
- Reset idle: reset high then low, no start -> tx=1, busy=0, done=0, byte_idx=0 for 100 cycles.
- Single frame: cmd="@" (0x40), payload=0 except byte1="A" (0x41), start for 1 cycle -> tx low one cycle later. A bench UART sampler at bit centres decodes bytes 0x40, 0x41, 0x00 x15, 0x40. done pulses once, exactly 720 clocks after the first tx fall. busy is low the next cycle.
- Ignored start: start pulsed again at byte_idx=5 with cmd=0x42 -> the frame is unchanged (still ends 0x40) and there is no second frame.
- Back-to-back: start held high through done with cmd=0x44 for the second frame -> busy never drops. The first start bit of frame 2 begins on the edge after done. Frame 2 decodes with 0x44 first and last.
- Reset mid-frame: reset asserted during DATA of byte 3 -> tx=1 asynchronously, busy=0, no done. A new start afterwards sends a complete correct frame.
- Gap (UART_FRAME_TX_GAP_EN, GAP_BITS=2) -> 4*2=8 high clocks after each stop bit (bytes 0..16 only). Total frame length is 214 bit-times = 856 clocks to done.

Source files
------------

// File: rtl/uart_frame_tx.sv
// 8N1 transmitter for the badge command frame {cmd, payload[127:0], cmd}, LSB byte first.
// Optional macro UART_FRAME_TX_GAP_EN inserts GAP_BITS idle bit-times after every stop bit except the last.
module uart_frame_tx #(
  parameter int BR_LIMIT    = 672,
  parameter int BR_BITS     = 10,
  parameter int SAMPLES     = 16,
  parameter int FRAME_BYTES = 18,
  parameter int GAP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   cmd,
  input  logic [127:0] payload,
  output logic         busy,
  output logic         done,
  output logic [4:0]   byte_idx,
  output logic         tx
);

  localparam int SMP_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam logic [BR_BITS-1:0] TICK_MAX   = BR_BITS'(BR_LIMIT - 1);
  localparam logic [SMP_W-1:0]   SAMPLE_MAX = SMP_W'(SAMPLES - 1);
  localparam logic [4:0]         LAST_BYTE  = 5'(FRAME_BYTES - 1);

  // Bad parameter sets stop elaboration rather than producing a silently wrong frame.
  generate
    if (FRAME_BYTES != 18 || (2 ** BR_BITS) <= BR_LIMIT || SAMPLES < 1 || GAP_BITS < 1) begin : g_param_check
      $error("uart_frame_tx: unsupported parameter set");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_FRAME_TX_GAP_EN
    ,GAP  = 3'd4
`endif
  } state_t;

  state_t               state_reg;
  logic [BR_BITS-1:0]   tick_cnt_reg;
  logic [SMP_W-1:0]     sample_cnt_reg;
  logic [2:0]           bit_cnt_reg;
  logic [143:0]         shift_reg;
  logic                 bit_end;

`ifdef UART_FRAME_TX_GAP_EN
  localparam int GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_BITS - 1);
  logic [GAP_W-1:0]     gap_cnt_reg;
`endif

  // Last clock of the current bit-time.
  assign bit_end = (tick_cnt_reg == TICK_MAX) && (sample_cnt_reg == SAMPLE_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      byte_idx       <= '0;
      tx             <= 1'b1;
`ifdef UART_FRAME_TX_GAP_EN
      gap_cnt_reg    <= '0;
`endif
    end else begin
      done <= 1'b0;

      // Baud timing restarts at every bit boundary and is held at zero while idle.
      if (state_reg == IDLE || bit_end) begin
        tick_cnt_reg   <= '0;
        sample_cnt_reg <= '0;
      end else if (tick_cnt_reg == TICK_MAX) begin
        tick_cnt_reg   <= '0;
        sample_cnt_reg <= sample_cnt_reg + SMP_W'(1);
      end else begin
        tick_cnt_reg   <= tick_cnt_reg + BR_BITS'(1);
      end

      case (state_reg)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            shift_reg <= {cmd, payload, cmd};
            state_reg <= START;
            busy      <= 1'b1;
            byte_idx  <= '0;
            tx        <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
            tx          <= shift_reg[0];
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_cnt_reg == 3'd7) begin
              state_reg <= STOP;
              tx        <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              tx          <= shift_reg[3'(bit_cnt_reg + 3'd1)];
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            if (byte_idx == LAST_BYTE) begin
              done     <= 1'b1;
              byte_idx <= '0;
              // A start seen on the completing edge chains straight into the next frame.
              if (start) begin
                shift_reg <= {cmd, payload, cmd};
                state_reg <= START;
                tx        <= 1'b0;
              end else begin
                state_reg <= IDLE;
                busy      <= 1'b0;
              end
            end else begin
              shift_reg <= shift_reg >> 8;
              byte_idx  <= byte_idx + 5'd1;
`ifdef UART_FRAME_TX_GAP_EN
              state_reg   <= GAP;
              gap_cnt_reg <= '0;
              tx          <= 1'b1;
`else
              state_reg <= START;
              tx        <= 1'b0;
`endif
            end
          end
        end

`ifdef UART_FRAME_TX_GAP_EN
        GAP: begin
          if (bit_end) begin
            if (gap_cnt_reg == GAP_MAX) begin
              state_reg <= START;
              tx        <= 1'b0;
            end else begin
              gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end
          end
        end
`endif

        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
          tx        <= 1'b1;
        end
      endcase
    end
  end

endmodule
